dmem_sized_ws: RTL and testbench

- Parametrised byte-addressed data memory for the MIPS core, replacing the fixed 256x8 word-only memory.
- Supports byte, halfword and word loads and stores, with optional sign extension on loads.
- Byte order is big-endian.
- Access latency is programmable through a req/ready/done handshake, so the core's MEM stage can be tested against slow memory.
- Sits between the core's MEM stage and the load/store datapath.

---
 rtl/dmem_sized_ws.sv | 182 ++++++++++++++++++
 tb/tb_dmem_sized_ws.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sized_ws.sv
// Byte-addressed data memory with byte/half/word access, big-endian lanes,
// optional sign extension and a programmable-latency req/ready/done handshake.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word or size=11 completes with err=1, no side effects
//   undefined : err tied 0, low address bits masked, size=11 treated as word
module dmem_sized_ws #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              commit;

  logic [7:0] mem [Depth];

  // With zero wait states the commit edge is the accept edge, so the live
  // inputs are used while idle and the latched copies afterwards.
  logic              idle;
  logic              a_we;
  logic [1:0]        a_size;
  logic              a_sext;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;

  assign idle    = (state_q == StIdle);
  assign a_we    = idle ? we       : we_q;
  assign a_size  = idle ? size     : size_q;
  assign a_sext  = idle ? sign_ext : sext_q;
  assign a_addr  = idle ? addr     : addr_q;
  assign a_wdata = idle ? wdata    : wdata_q;

  // Address alignment and illegal-access detection.
  logic              bad;
  logic [ADDR_W-1:0] base, base1, base2, base3;

  always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
    bad  = (a_size == 2'b11) || ((a_size == 2'b01) && a_addr[0]) ||
           ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
    base = a_addr;
`else
    bad = 1'b0;
    case (a_size)
      2'b00:   base = a_addr;
      2'b01:   base = {a_addr[ADDR_W-1:1], 1'b0};
      default: base = {a_addr[ADDR_W-1:2], 2'b00};
    endcase
`endif
  end

  assign base1 = base + ADDR_W'(1);
  assign base2 = base + ADDR_W'(2);
  assign base3 = base + ADDR_W'(3);

  // Load formatting: big-endian lanes, right-justified, optional sign fill.
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] ld;

  always_comb begin
    b0 = mem[base];
    b1 = mem[base1];
    b2 = mem[base2];
    b3 = mem[base3];
    case (a_size)
      2'b00:   ld = {{24{a_sext & b0[7]}}, b0};
      2'b01:   ld = {{16{a_sext & b0[7]}}, b0, b1};
      default: ld = {b0, b1, b2, b3};
    endcase
  end

  // Handshake FSM next state; commit marks the edge entering StResp.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = StResp;
            commit  = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state, request latches and registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= commit;
      err_q   <= commit & bad;
      if (idle && req) begin
        we_q    <= we;
        size_q  <= size;
        sext_q  <= sign_ext;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (commit && !a_we && !bad) rdata_q <= ld;
    end
  end

  // Byte-lane store at the commit edge; reset on that edge suppresses it.
  always_ff @(posedge clk) begin
    if (reset_n && commit && a_we && !bad) begin
      case (a_size)
        2'b00: mem[base] <= a_wdata[7:0];
        2'b01: begin
          mem[base]  <= a_wdata[15:8];
          mem[base1] <= a_wdata[7:0];
        end
        default: begin
          mem[base]  <= a_wdata[31:24];
          mem[base1] <= a_wdata[23:16];
          mem[base2] <= a_wdata[15:8];
          mem[base3] <= a_wdata[7:0];
        end
      endcase
    end
  end

  assign ready = idle;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_sized_ws.sv
// Bench for dmem_sized_ws: three instances (WAIT_STATES = 1, 0, 3), directed
// table, back-to-back timing, reset abort and randomized model checks.
module tb_dmem_sized_ws;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn  [3];
  logic        req   [3];
  logic        we    [3];
  logic [1:0]  size  [3];
  logic        sext  [3];
  logic [9:0]  addr  [3];
  logic [31:0] wdata [3];
  logic        ready [3];
  logic        done  [3];
  logic [31:0] rdata [3];
  logic        err   [3];

  dmem_sized_ws #(.ADDR_W(10), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset_n(rstn[0]), .req(req[0]), .we(we[0]), .size(size[0]),
    .sign_ext(sext[0]), .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]),
    .done(done[0]), .rdata(rdata[0]), .err(err[0])
  );
  dmem_sized_ws #(.ADDR_W(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset_n(rstn[1]), .req(req[1]), .we(we[1]), .size(size[1]),
    .sign_ext(sext[1]), .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]),
    .done(done[1]), .rdata(rdata[1]), .err(err[1])
  );
  dmem_sized_ws #(.ADDR_W(10), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset_n(rstn[2]), .req(req[2]), .we(we[2]), .size(size[2]),
    .sign_ext(sext[2]), .addr(addr[2]), .wdata(wdata[2]), .ready(ready[2]),
    .done(done[2]), .rdata(rdata[2]), .err(err[2])
  );

  int errors = 0;
  int checks = 0;

  // Reference: byte array per instance plus the expected held rdata.
  logic [7:0]  mref [3][1024];
  logic [31:0] rexp [3];

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One access: wait for ready, present request, then scramble the inputs so
  // only latched values can produce the result. lat counts cycles to done.
  task automatic access(input int k, input logic w, input logic [1:0] sz, input logic se,
                        input logic [9:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
    int n;
    rd  = 32'd0;
    e   = 1'b0;
    lat = 0;
    @(negedge clk);
    n = 0;
    while (!ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    req[k] = 1'b1; we[k] = w; size[k] = sz; sext[k] = se; addr[k] = a; wdata[k] = wd;
    @(posedge clk);
    #1;
    req[k]   = 1'b0;
    we[k]    = 1'($urandom);
    size[k]  = 2'($urandom);
    sext[k]  = 1'($urandom);
    addr[k]  = 10'($urandom);
    wdata[k] = $urandom;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done[k]) begin
        lat = i;
        rd  = rdata[k];
        e   = err[k];
        break;
      end
    end
  endtask

  // Model-checked access computed from the byte-lane rules.
  task automatic mop(input int k, input logic w, input logic [1:0] sz, input logic se,
                     input logic [9:0] a, input logic [31:0] wd);
    logic [1:0]  s;
    bit          mis;
    int          nb;
    int          base;
    logic [31:0] v;
    logic [31:0] rd;
    logic        e;
    int          lat;
    s   = (!Trap && sz == 2'b11) ? 2'b10 : sz;
    mis = Trap && ((sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
    nb  = 1 << s;
    base = Trap ? int'(a) : (int'(a) / nb) * nb;
    if (!mis) begin
      if (w) begin
        for (int i = 0; i < nb && i < 4; i++) begin
          v = wd >> (8 * (nb - 1 - i));
          mref[k][base + i] = v[7:0];
        end
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb && i < 4; i++) v = (v << 8) | {24'd0, mref[k][base + i]};
        if (se && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rexp[k] = v;
      end
    end
    access(k, w, sz, se, a, wd, rd, e, lat);
    chk($sformatf("m%0d_lat", k), 32'(lat), 32'(1 + ws_of(k)));
    chk($sformatf("m%0d_err a=%h sz=%0d", k, a, sz), 32'(e), 32'(mis));
    chk($sformatf("m%0d_rdata a=%h sz=%0d w=%0d", k, a, sz, w), rd, rexp[k]);
  endtask

  // Hold req high and check the ready/done cadence of period WAIT_STATES+2.
  task automatic b2b(input int k);
    int p;
    int n;
    p = ws_of(k) + 2;
    @(negedge clk);
    n = 0;
    while (!ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    req[k] = 1'b1; we[k] = 1'b0; size[k] = 2'b10; sext[k] = 1'b0; addr[k] = 10'h100;
    for (int j = 0; j < 3 * p; j++) begin
      chk($sformatf("b2b%0d_ready j=%0d", k, j), 32'(ready[k]), 32'(j % p == 0));
      chk($sformatf("b2b%0d_done j=%0d", k, j), 32'(done[k]), 32'(j % p == p - 1));
      @(negedge clk);
    end
    req[k] = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        se;
    logic [9:0]  a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 10'h010, 32'h0,        32'h000000DE, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 10'h013, 32'h0,        32'h000000EF, 1'b0};
    tbl[4]  = '{1'b1, 2'd2, 1'b0, 10'h020, 32'h00000000, 32'h000000EF, 1'b0};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 10'h022, 32'h00008001, 32'h000000EF, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 10'h020, 32'h000000F0, 32'h000000EF, 1'b0};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 10'h020, 32'h0,        32'hF0008001, 1'b0};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 10'h022, 32'h0,        32'hFFFF8001, 1'b0};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 10'h022, 32'h0,        32'h00008001, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 10'h020, 32'h0,        32'hFFFFFFF0, 1'b0};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 10'h030, 32'h11223344, 32'hFFFFFFF0, 1'b0};
    tbl[12] = '{1'b1, 2'd1, 1'b0, 10'h031, 32'h0000AAAA, 32'hFFFFFFF0, Trap};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 10'h030, 32'h0,
                Trap ? 32'h11223344 : 32'hAAAA3344, 1'b0};
    tbl[14] = '{1'b0, 2'd3, 1'b0, 10'h032, 32'h0,
                Trap ? 32'h11223344 : 32'hAAAA3344, Trap};
    tbl[15] = '{1'b0, 2'd1, 1'b1, 10'h033, 32'h0,
                Trap ? 32'h11223344 : 32'h00003344, Trap};

    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; size[k] = 2'b00; sext[k] = 1'b0;
      addr[k] = 10'd0; wdata[k] = 32'd0; rexp[k] = 32'd0;
    end

    // Reset and idle state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_ready", k), 32'(ready[k]), 32'd1);
      chk($sformatf("rst%0d_done", k), 32'(done[k]), 32'd0);
      chk($sformatf("rst%0d_err", k), 32'(err[k]), 32'd0);
      chk($sformatf("rst%0d_rdata", k), rdata[k], 32'd0);
    end

    // Directed table on the WAIT_STATES=1 instance.
    for (int i = 0; i < 16; i++) begin
      access(0, tbl[i].w, tbl[i].sz, tbl[i].se, tbl[i].a, tbl[i].wd, rd, e, lat);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd2);
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].eerr));
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].erd);
    end

    // Preload, cadence, then randomized traffic on WAIT_STATES=0 and 3.
    for (int k = 1; k < 3; k++) begin
      for (int a = 'h100; a < 'h140; a += 4) mop(k, 1'b1, 2'd2, 1'b0, 10'(a), $urandom);
      mop(k, 1'b1, 2'd2, 1'b0, 10'h040, 32'h00000000);
      b2b(k);
      mop(k, 1'b0, 2'd2, 1'b0, 10'h100, 32'h0);
      for (int i = 0; i < 80; i++) begin
        mop(k, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
            10'(32'h100 + $urandom_range(0, 63)), $urandom);
      end
    end

    // Reset in the second wait cycle aborts a store on WAIT_STATES=3.
    @(negedge clk);
    for (int n = 0; n < 50 && !ready[2]; n++) @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; size[2] = 2'd2; sext[2] = 1'b0;
    addr[2] = 10'h040; wdata[2] = 32'h00000055;
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    @(negedge clk);
    chk("abort_w1_done", 32'(done[2]), 32'd0);
    @(negedge clk);
    chk("abort_w2_done", 32'(done[2]), 32'd0);
    rstn[2] = 1'b0;
    @(negedge clk);
    rstn[2] = 1'b1;
    chk("abort_ready", 32'(ready[2]), 32'd1);
    chk("abort_rdata", rdata[2], 32'd0);
    for (int n = 0; n < 6; n++) begin
      chk($sformatf("abort_nodone%0d", n), 32'(done[2]), 32'd0);
      @(negedge clk);
    end
    rexp[2] = 32'd0;
    mop(2, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
